// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
//   - fetch_state_t : fetch FSM encoding (FETCH, HOLD, KILL)
//   - FETCH_NOP     : bubble instruction word (sll $0,$0,0)
//   - OPC_HI/OPC_LO : opcode field position inside an instruction word
//   - OP_*          : primary opcodes recognised by the control decoder
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding or about to be issued
    HOLD  = 2'd1,  // fetched word parked in the skid buffer, waiting on Stall
    KILL  = 2'd2   // redirected while a request is in flight; drain it, drop data
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a word that returned from memory while the
// stage was stalled.
//   clk, rst        : clock, async active-high reset
//   load            : capture instr_in / pc_plus4_in, mark full
//   drain           : entry consumed by IF/ID, mark empty
//   clear           : entry discarded (redirect), mark empty
//   instr, pc_plus4 : stored entry
//   full            : entry holds a live word
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_plus4_in,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= FETCH_NOP;
      pc_plus4 <= '0;
      full     <= 1'b0;
    end else if (clear || drain) begin
      full <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      full     <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, runs a req/ack handshake with instruction memory, honours
// hazard stalls and branch redirects, and presents a registered instruction,
// its PC+4 and a valid bit to decode.
//   clk, rst                  : clock, async active-high reset
//   imem_req/addr/ack/rdata   : instruction memory handshake
//   Stall                     : hold IF/ID and PC
//   BranchTaken/BranchTarget  : redirect (wins over Stall)
//   INSTR, PC_PLUS4, IF_VALID : IF/ID register
//   OPCODE                    : INSTR[31:26]
// Optional (macro FETCH_PERF_EN): bubble_cnt, redirect_cnt saturating counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSTR = FETCH_NOP
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [31:0]       INSTR,
  output logic [ADDR_W-1:0] PC_PLUS4,
  output logic              IF_VALID,
  output logic [5:0]        OPCODE
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       redirect_cnt
`endif
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, tgt;
  logic [ADDR_W-1:0] ktgt, ktgt_n;
  logic [31:0]       instr_n;
  logic [ADDR_W-1:0] pc4_n;
  logic              valid_n;
  logic              req_st;
  logic              sk_load, sk_drain, sk_clear, sk_full;
  logic [31:0]       sk_instr;
  logic [ADDR_W-1:0] sk_pc4;
  logic              unused_tgt_lsb;

  assign pc_inc = pc + ADDR_W'(4);   // wraps modulo 2^ADDR_W
  assign tgt    = {BranchTarget[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lsb = ^{BranchTarget[1:0], sk_full};

  fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .load        (sk_load),
    .drain       (sk_drain),
    .clear       (sk_clear),
    .instr_in    (imem_rdata),
    .pc_plus4_in (pc_inc),
    .instr       (sk_instr),
    .pc_plus4    (sk_pc4),
    .full        (sk_full)
  );

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ktgt_n   = ktgt;
    instr_n  = INSTR;
    pc4_n    = PC_PLUS4;
    valid_n  = IF_VALID;
    sk_load  = 1'b0;
    sk_drain = 1'b0;
    sk_clear = 1'b0;
    req_st   = 1'b1;
    case (state)
      FETCH: begin
        if (BranchTaken) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          if (imem_ack) begin
            pc_n = tgt;
          end else begin
            // cannot abandon the request: finish it in KILL, then redirect
            ktgt_n  = tgt;
            state_n = KILL;
          end
        end else if (imem_ack) begin
          if (!Stall) begin
            instr_n = imem_rdata;
            pc4_n   = pc_inc;
            valid_n = 1'b1;
            pc_n    = pc_inc;
          end else begin
            sk_load = 1'b1;
            state_n = HOLD;
          end
        end else if (!Stall) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
        end
      end
      HOLD: begin
        req_st = 1'b0;
        if (BranchTaken) begin
          sk_clear = 1'b1;
          pc_n     = tgt;
          valid_n  = 1'b0;
          instr_n  = NOP_INSTR;
          state_n  = FETCH;
        end else if (!Stall) begin
          sk_drain = 1'b1;
          instr_n  = sk_instr;
          pc4_n    = sk_pc4;
          valid_n  = 1'b1;
          pc_n     = pc_inc;
          state_n  = FETCH;
        end
      end
      KILL: begin
        valid_n = 1'b0;
        instr_n = NOP_INSTR;
        if (BranchTaken) begin
          // newest redirect wins
          ktgt_n = tgt;
          if (imem_ack) begin
            pc_n    = tgt;
            state_n = FETCH;
          end
        end else if (imem_ack) begin
          pc_n    = ktgt;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ktgt     <= '0;
      INSTR    <= NOP_INSTR;
      PC_PLUS4 <= '0;
      IF_VALID <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ktgt     <= ktgt_n;
      INSTR    <= instr_n;
      PC_PLUS4 <= pc4_n;
      IF_VALID <= valid_n;
    end
  end

  // request drops the instant reset asserts, even mid-handshake
  assign imem_req  = req_st & ~rst;
  assign imem_addr = pc;
  assign OPCODE    = opcode_of(INSTR);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!IF_VALID && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (BranchTaken && redirect_cnt != 32'hFFFF_FFFF)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
